// File: rtl/lstm_pkg.sv
// +--------------------------------------------------------------------------+
// | lstm_pkg : shared state encoding and default sizes for the LSTM sequencer |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package lstm_pkg;

  localparam int LSTM_M           = 2;
  localparam int LSTM_N           = 4;
  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_FRACT_WIDTH = 8;

  localparam int LSTM_H_WIDTH = LSTM_M * LSTM_DATA_WIDTH;
  localparam int LSTM_X_WIDTH = LSTM_N * LSTM_DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_X = 3'd1,
    ST_SETTLE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_DONE   = 3'd4
  } lstm_state_t;

endpackage

`default_nettype wire

// File: rtl/lstm_settle_cnt.sv
// +--------------------------------------------------------------------------+
// | lstm_settle_cnt : loadable down-counter with zero flag for cell settling  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module lstm_settle_cnt #(
  parameter int CELL_LAT = 2,
  parameter int CNT_W    = $clog2(CELL_LAT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/lstm_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | lstm_seq_ctrl : steps the combinational lstm cell over seq_len inputs.    |
// | Optional macro LSTM_STATE_PRELOAD_EN adds h0/c0 initial-state ports.      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int M           = LSTM_M,
  parameter int N           = LSTM_N,
  parameter int DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int FRACT_WIDTH = LSTM_FRACT_WIDTH,
  parameter int LEN_W       = 8,
  parameter int CELL_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_W-1:0]        seq_len,
  output logic                    busy,
  output logic                    done,
  output logic [LEN_W-1:0]        step_idx,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [N*DATA_WIDTH-1:0] x_data,
  output logic [N*DATA_WIDTH-1:0] cell_xt,
  output logic [M*DATA_WIDTH-1:0] cell_htI,
  output logic [M*DATA_WIDTH-1:0] cell_ctI,
  input  logic [M*DATA_WIDTH-1:0] cell_htO,
  input  logic [M*DATA_WIDTH-1:0] cell_ctO,
`ifdef LSTM_STATE_PRELOAD_EN
  input  logic [M*DATA_WIDTH-1:0] h0,
  input  logic [M*DATA_WIDTH-1:0] c0,
`endif
  output logic                    h_valid,
  input  logic                    h_ready,
  output logic [M*DATA_WIDTH-1:0] h_data
);

  localparam int               CNT_W       = $clog2(CELL_LAT) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(CELL_LAT - 1);

  lstm_state_t             state;
  logic [LEN_W-1:0]        seq_len_q;
  logic [N*DATA_WIDTH-1:0] xt_q;
  logic [M*DATA_WIDTH-1:0] ht_q;
  logic [M*DATA_WIDTH-1:0] ct_q;
  logic [M*DATA_WIDTH-1:0] ht_init;
  logic [M*DATA_WIDTH-1:0] ct_init;
  logic                    cnt_load;
  logic                    cnt_zero;

  // Fraction bits must fit inside an element; nothing else depends on them here.
  if (FRACT_WIDTH > DATA_WIDTH) begin : g_fract_range_bad
  end

`ifdef LSTM_STATE_PRELOAD_EN
  assign ht_init = h0;
  assign ct_init = c0;
`else
  assign ht_init = '0;
  assign ct_init = '0;
`endif

  assign cnt_load = (state == ST_WAIT_X) && x_valid && !abort;

  lstm_settle_cnt #(
    .CELL_LAT (CELL_LAT),
    .CNT_W    (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (state == ST_SETTLE),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_ready   <= 1'b0;
      h_valid   <= 1'b0;
      step_idx  <= '0;
      seq_len_q <= '0;
      xt_q      <= '0;
      ht_q      <= '0;
      ct_q      <= '0;
    end else if (abort) begin
      // Datapath registers deliberately keep their contents across an abort.
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      x_ready <= 1'b0;
      h_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            seq_len_q <= seq_len;
            step_idx  <= '0;
            ht_q      <= ht_init;
            ct_q      <= ct_init;
            busy      <= 1'b1;
            if (seq_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_WAIT_X;
              x_ready <= 1'b1;
            end
          end
        end
        ST_WAIT_X: begin
          if (x_valid) begin
            xt_q    <= x_data;
            x_ready <= 1'b0;
            state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            ht_q    <= cell_htO;
            ct_q    <= cell_ctO;
            h_valid <= 1'b1;
            state   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (h_ready) begin
            h_valid  <= 1'b0;
            step_idx <= step_idx + LEN_W'(1);
            if (step_idx == seq_len_q - LEN_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_WAIT_X;
              x_ready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          x_ready <= 1'b0;
          h_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cell_xt  = xt_q;
  assign cell_htI = ht_q;
  assign cell_ctI = ct_q;
  assign h_data   = ht_q;

endmodule

`default_nettype wire

// File: tb/tb_lstm_seq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_lstm_seq_ctrl : randomized self-checking bench with a stand-in cell.   |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lstm_seq_ctrl;

  localparam int M        = 2;
  localparam int N        = 4;
  localparam int DW       = 16;
  localparam int LEN_W    = 8;
  localparam int CELL_LAT = 2;
  localparam int HW       = M * DW;
  localparam int XW       = N * DW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] seq_len = '0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] step_idx;
  logic             x_valid = 1'b0;
  logic             x_ready;
  logic [XW-1:0]    x_data = '0;
  logic [XW-1:0]    cell_xt;
  logic [HW-1:0]    cell_htI;
  logic [HW-1:0]    cell_ctI;
  logic [HW-1:0]    cell_htO;
  logic [HW-1:0]    cell_ctO;
  logic             h_valid;
  logic             h_ready = 1'b0;
  logic [HW-1:0]    h_data;
`ifdef LSTM_STATE_PRELOAD_EN
  logic [HW-1:0]    h0 = '0;
  logic [HW-1:0]    c0 = '0;
`endif

  int tests = 0;
  int fails = 0;
  logic [HW-1:0] pre_h = {2{16'h0100}};
  logic [HW-1:0] pre_c = {2{16'h0100}};
  logic [HW-1:0] mh, mc;

  lstm_seq_ctrl #(
    .M(M), .N(N), .DATA_WIDTH(DW), .FRACT_WIDTH(8), .LEN_W(LEN_W), .CELL_LAT(CELL_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seq_len(seq_len),
    .busy(busy), .done(done), .step_idx(step_idx),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .cell_xt(cell_xt), .cell_htI(cell_htI), .cell_ctI(cell_ctI),
    .cell_htO(cell_htO), .cell_ctO(cell_ctO),
`ifdef LSTM_STATE_PRELOAD_EN
    .h0(h0), .c0(c0),
`endif
    .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data)
  );

  always #5 clk = ~clk;

  // Stand-in cell: arbitrary mixing so every step depends on x, ht and ct.
  function automatic logic [HW-1:0] cell_h(input logic [XW-1:0] x, input logic [HW-1:0] h,
                                           input logic [HW-1:0] c);
    logic [HW-1:0] r;
    for (int i = 0; i < M; i++)
      r[i*DW +: DW] = x[i*DW +: DW] + (h[i*DW +: DW] ^ c[i*DW +: DW]) + 16'(i + 1);
    return r;
  endfunction

  function automatic logic [HW-1:0] cell_c(input logic [XW-1:0] x, input logic [HW-1:0] h,
                                           input logic [HW-1:0] c);
    logic [HW-1:0] r;
    for (int i = 0; i < M; i++)
      r[i*DW +: DW] = c[i*DW +: DW] + x[(i+2)*DW +: DW] - h[i*DW +: DW] + 16'h0011;
    return r;
  endfunction

  assign cell_htO = cell_h(cell_xt, cell_htI, cell_ctI);
  assign cell_ctO = cell_c(cell_xt, cell_htI, cell_ctI);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_x_ready", 64'(x_ready), 64'd0);
    check("rst_h_valid", 64'(h_valid), 64'd0);
    check("rst_step_idx", 64'(step_idx), 64'd0);
    check("rst_cell_xt", 64'(cell_xt), 64'd0);
    check("rst_cell_htI", 64'(cell_htI), 64'd0);
    check("rst_cell_ctI", 64'(cell_ctI), 64'd0);
  endtask

  // One sequence; abort_step/reset_step select a step to interrupt (-1 = none).
  task automatic run_seq(input int len, input bit use_fixed, input logic [XW-1:0] fixed_x,
                         input int bp, input int abort_step, input int reset_step);
    logic [XW-1:0] v;
    logic [HW-1:0] eh, ec, init_h, init_c;
    int n;
    bit acc;
`ifdef LSTM_STATE_PRELOAD_EN
    h0 = pre_h; c0 = pre_c; init_h = pre_h; init_c = pre_c;
`else
    init_h = '0; init_c = '0;
`endif
    @(negedge clk);
    start = 1'b1; seq_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0; seq_len = LEN_W'($urandom);
    mh = init_h; mc = init_c;
    check("start_htI", 64'(cell_htI), 64'(init_h));
    check("start_ctI", 64'(cell_ctI), 64'(init_c));
    if (len == 0) begin
      check("zl_done", 64'(done), 64'd1);
      check("zl_x_ready", 64'(x_ready), 64'd0);
      check("zl_h_valid", 64'(h_valid), 64'd0);
      @(negedge clk);
      check("zl_done_pulse", 64'(done), 64'd0);
      check("zl_busy_end", 64'(busy), 64'd0);
      return;
    end
    check("start_busy", 64'(busy), 64'd1);
    check("start_step_idx", 64'(step_idx), 64'd0);
    for (int k = 0; k < len; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      v = use_fixed ? fixed_x : {$urandom, $urandom};
      x_valid = 1'b1; x_data = v; n = 0;
      do begin
        acc = x_ready;
        @(negedge clk);
        n++;
      end while (!acc && n < 50);
      x_valid = 1'b0; x_data = {$urandom, $urandom};
      if (!acc) begin
        check("x_ready_timeout", 64'd0, 64'd1);
        return;
      end
      check("xt_capture", 64'(cell_xt), 64'(v));
      check("x_ready_drop", 64'(x_ready), 64'd0);
      check("htI_hold", 64'(cell_htI), 64'(mh));
      if (k == abort_step) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_x_ready", 64'(x_ready), 64'd0);
        check("abort_h_valid", 64'(h_valid), 64'd0);
        check("abort_xt_hold", 64'(cell_xt), 64'(v));
        check("abort_htI_hold", 64'(cell_htI), 64'(mh));
        repeat (3) begin
          check("abort_no_done", 64'(done), 64'd0);
          @(negedge clk);
        end
        return;
      end
      n = 0;
      while (!h_valid && n < 50) begin
        check("settle_xt_stable", 64'(cell_xt), 64'(v));
        @(negedge clk);
        n++;
      end
      check("settle_latency", 64'(n), 64'(CELL_LAT));
      eh = cell_h(v, mh, mc);
      ec = cell_c(v, mh, mc);
      mh = eh; mc = ec;
      check("h_data", 64'(h_data), 64'(eh));
      check("cell_htI", 64'(cell_htI), 64'(eh));
      check("cell_ctI", 64'(cell_ctI), 64'(ec));
      check("step_idx", 64'(step_idx), 64'(k));
      if (k == reset_step) begin
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      for (int b = 0; b < bp; b++) begin
        if (b == 1) begin
          start = 1'b1; seq_len = LEN_W'($urandom_range(1, 9));
        end
        @(negedge clk);
        start = 1'b0;
        check("bp_h_valid", 64'(h_valid), 64'd1);
        check("bp_h_data", 64'(h_data), 64'(eh));
        check("bp_x_ready", 64'(x_ready), 64'd0);
        check("bp_step_idx", 64'(step_idx), 64'(k));
      end
      h_ready = 1'b1;
      @(negedge clk);
      h_ready = 1'b0;
      check("h_valid_drop", 64'(h_valid), 64'd0);
      if (k == len - 1) begin
        check("done", 64'(done), 64'd1);
        check("busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        check("busy_end", 64'(busy), 64'd0);
      end else begin
        check("done_early", 64'(done), 64'd0);
        check("next_x_ready", 64'(x_ready), 64'd1);
      end
    end
  endtask

  initial begin
    logic [XW-1:0] fx;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;

    fx = {16'h0080, 16'h0000, 16'h0080, 16'h0000};
    run_seq(1, 1'b1, fx, 0, -1, -1);
    fx = {4{16'h0040}};
    run_seq(3, 1'b1, fx, 0, -1, -1);
    run_seq(2, 1'b0, '0, 5, -1, -1);
    run_seq(0, 1'b0, '0, 0, -1, -1);
    run_seq(3, 1'b0, '0, 0, 1, -1);
    run_seq(3, 1'b0, '0, 1, -1, -1);
    run_seq(2, 1'b0, '0, 0, -1, 0);
    run_seq(1, 1'b0, '0, 0, -1, -1);
    for (int r = 0; r < 10; r++) begin
      pre_h = $urandom;
      pre_c = $urandom;
      run_seq($urandom_range(1, 5), 1'b0, '0, $urandom_range(0, 3), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequencer that runs the combinational `lstm` cell over a sequence of `seq_len` timesteps. Each input vector is accepted on a valid/ready stream and the cell is allowed a fixed settle time. The cell's ctO/htO are registered and fed back as ctI/htI for the next step, and each ht is emitted on an output stream. It sits between the CNN feature stream and the CTC/FC head. The weight and bias ports are driven to the cell directly by the parent and are not handled here.

## Interface
- `M`, 2: hidden size (elements of ht/ct).
- `N`, 4: input size (elements of xt).
- `DATA_WIDTH`, 16: signed fixed-point element width.
- `FRACT_WIDTH`, 8: fractional bits. Not used arithmetically; carried for the package.
- `LEN_W`, 8: width of `seq_len`.
- `CELL_LAT`, 2: settle cycles allowed for the cell, ≥1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a sequence; sampled in IDLE only.
- `abort` in 1: synchronous abort to IDLE.
- `seq_len` in LEN_W: number of steps, sampled on `start`.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse when the sequence completes.
- `step_idx` out LEN_W: index of the current step.
- `x_valid`/`x_ready` in/out 1: input handshake.
- `x_data` in N*DATA_WIDTH: input vector.
- `cell_xt` out N*DATA_WIDTH: to the cell's xt input.
- `cell_htI` out M*DATA_WIDTH: to the cell's htI input.
- `cell_ctI` out M*DATA_WIDTH: to the cell's ctI input.
- `cell_htO` in M*DATA_WIDTH: from the cell's htO output.
- `cell_ctO` in M*DATA_WIDTH: from the cell's ctO output.
- `h_valid`/`h_ready` out/in 1: output handshake.
- `h_data` out M*DATA_WIDTH: equals `cell_htI` (the registered ht).

## Operation
- States:
  - IDLE: on `start`, latch `seq_len`, clear `step_idx`, clear ht/ct state, then go to WAIT_X. If `seq_len`==0, go to DONE instead.
  - WAIT_X: `x_ready`=1. On `x_valid&&x_ready`, register `x_data` into `cell_xt`, load the settle counter with CELL_LAT−1, and go to SETTLE.
  - SETTLE: decrement the counter. When the counter is 0, capture `cell_htO`→ht_q and `cell_ctO`→ct_q, then go to EMIT.
  - EMIT: `h_valid`=1. On `h_ready`, increment `step_idx`. Go to DONE if `step_idx`==seq_len−1, otherwise go to WAIT_X.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- ht_q/ct_q drive `cell_htI`/`cell_ctI`. They change only at the SETTLE capture and at a `start` clear.
- Cell inputs are stable for all CELL_LAT settle cycles.
- `start` outside IDLE is ignored.
- `abort` has priority over every transition. From any state it goes to IDLE next cycle with no `done`. ht/ct/xt registers hold their values.
- No arithmetic is performed here. Registers are pure DATA_WIDTH copies; there is no saturation or rounding.

## Timing
- Reset values: state IDLE; `busy`, `done`, `x_ready`, `h_valid` = 0; `step_idx`, `cell_xt`, ht_q, ct_q = 0.
- With `x_valid` and `h_ready` held high, a step occupies CELL_LAT+2 cycles:
  - accept at cycle T;
  - capture at the end of T+CELL_LAT;
  - `h_valid` at T+CELL_LAT+1;
  - next `x_ready` at T+CELL_LAT+2.
- `h_valid` and `h_data` stay stable until `h_ready`. Backpressure stalls the sequence indefinitely.
- `done` is asserted the cycle after the last EMIT handshake. `busy` drops the cycle after that.
- `seq_len`==0: `done` is asserted 1 cycle after `start`, with no `x_ready` and no `h_valid`.
- An asynchronous `rst_n` assertion mid-sequence forces the reset values immediately.

## Configuration
- `LSTM_STATE_PRELOAD_EN` defined: adds input ports `h0` and `c0` (each M*DATA_WIDTH). On `start`, ht_q←h0 and ct_q←c0, which allows chained segments.
- Macro undefined: the ports are absent and `start` clears ht_q/ct_q to 0.

## Structure
- Package `lstm_pkg` holds:
  - the state enum (IDLE, WAIT_X, SETTLE, EMIT, DONE);
  - default M/N/DATA_WIDTH/FRACT_WIDTH localparams;
  - helper widths M*DATA_WIDTH and N*DATA_WIDTH.
- One sub-module, `lstm_settle_cnt`: a loadable down-counter with a zero flag, sized $clog2(CELL_LAT)+1.
- The `lstm` cell is instantiated by the parent, not inside this block.

## Test plan
1. Single step. Config: M=2, N=4, CELL_LAT=2, `seq_len`=1, ct/ht cleared, tb weights from the existing LSTM bench, xt={0,0.5,0,0.5} (0x0080 at odd indices). Required: one `h_valid` with h_data==cell htO; `done` 1 cycle after the handshake.
2. Chaining. `seq_len`=3 with constant x. Required: step k's `cell_htI`/`cell_ctI` equal step k−1's captured htO/ctO; three outputs; `step_idx` sequence 0,1,2.
3. Backpressure. Hold `h_ready`=0 for 5 cycles in EMIT. Required: `h_data` stable, `x_ready`=0, and no state change until release.
4. Zero length. `seq_len`=0. Required: `done` pulse at start+1, and no handshakes.
5. Abort. Assert `abort` in SETTLE of step 1 of 3. Required: IDLE next cycle, `done` never asserted, `busy`=0. A new `start` then runs normally.
6. Reset. Drop `rst_n` mid-EMIT. Required: all outputs at reset values asynchronously. With `LSTM_STATE_PRELOAD_EN`, h0=c0=0x0100 appears on `cell_htI`/`cell_ctI` after `start`.
